// File: rtl/keypad_pkg.sv
// keypad_pkg: shared state type, key code map and column drive patterns
// for the 4x4 keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } kp_state_t;

    // Indexed by {row, col}.
    localparam logic [3:0] CODE_MAP [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Active-low one-cold column drive, indexed by column number.
    localparam logic [3:0] COL_DRIVE [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    localparam logic [3:0] ROWS_IDLE  = 4'hF;
    localparam int         FIFO_DEPTH = 4;

    // Returns {exactly one row low, index of that row}.
    function automatic logic [2:0] single_row(input logic [3:0] rows);
        case (rows)
            4'b1110: single_row = 3'b100;
            4'b1101: single_row = 3'b101;
            4'b1011: single_row = 3'b110;
            4'b0111: single_row = 3'b111;
            default: single_row = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/kp_fifo.sv
// kp_fifo: small synchronous FIFO with valid/ready pop side and a drop
// indication on the push side. A push into a full FIFO succeeds only when
// a pop happens in the same cycle.
module kp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_drop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign do_pop    = out_valid && out_ready;
    assign do_push   = in_valid && ((count != CW'(DEPTH)) || do_pop);
    assign in_drop   = in_valid && !do_push;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce, ghost rejection
// and a valid/ready key output.
// Build option: define KEYPAD_FIFO_EN for a 4-entry output FIFO; otherwise
// the output stage is a single register.
//
// state   | meaning
// SCAN    | drive one column per dwell period, look for a single low row
// CONFIRM | column held, count stable cycles of the latched row pattern
// HOLD    | key accepted, waiting for all rows to go high
// RELEASE | count stable all-high cycles before resuming the scan
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_held,
    output logic       overflow
);
    localparam int SW = $clog2(SCAN_DIV + 1);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);

    kp_state_t     state;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [1:0]    col;
    logic [1:0]    row_idx;
    logic [3:0]    row_pat;
    logic [SW-1:0] dwell_cnt;
    logic [DW-1:0] deb_cnt;

    logic [2:0]    scan_hit;
    logic [1:0]    next_col;
    logic          rows_match;
    logic          dwell_done;
    logic          deb_done;
    logic          push;
    logic [3:0]    push_code;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_m <= ROWS_IDLE;
            rows_s <= ROWS_IDLE;
        end else begin
            rows_m <= row_n;
            rows_s <= rows_m;
        end
    end

    // Terminal-count compares, row decode and the push request.
    always_comb begin
        scan_hit   = single_row(rows_s);
        next_col   = col + 2'd1;
        rows_match = (rows_s == row_pat);
        dwell_done = (dwell_cnt == SW'(SCAN_DIV - 1));
        deb_done   = (deb_cnt == DW'(DEBOUNCE_CNT - 1));
        push       = (state == CONFIRM) && rows_match && deb_done;
        push_code  = CODE_MAP[{row_idx, col}];
    end

    // Scan / debounce state machine with registered column drive and key_held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SCAN;
            col       <= '0;
            col_n     <= COL_DRIVE[0];
            row_idx   <= '0;
            row_pat   <= ROWS_IDLE;
            dwell_cnt <= '0;
            deb_cnt   <= '0;
            key_held  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (!dwell_done) begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end else begin
                        dwell_cnt <= '0;
                        if (scan_hit[2]) begin
                            state   <= CONFIRM;
                            row_idx <= scan_hit[1:0];
                            row_pat <= rows_s;
                            deb_cnt <= '0;
                        end else begin
                            // idle rows or ghosting: move on
                            col   <= next_col;
                            col_n <= COL_DRIVE[next_col];
                        end
                    end
                end
                CONFIRM: begin
                    if (!rows_match) begin
                        state   <= SCAN;
                        deb_cnt <= '0;
                        col     <= next_col;
                        col_n   <= COL_DRIVE[next_col];
                    end else if (deb_done) begin
                        state    <= HOLD;
                        deb_cnt  <= '0;
                        key_held <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (rows_s == ROWS_IDLE) begin
                        state   <= RELEASE;
                        deb_cnt <= '0;
                    end
                end
                RELEASE: begin
                    if (rows_s != ROWS_IDLE) begin
                        state   <= HOLD;
                        deb_cnt <= '0;
                    end else if (deb_done) begin
                        state    <= SCAN;
                        deb_cnt  <= '0;
                        key_held <= 1'b0;
                        col      <= next_col;
                        col_n    <= COL_DRIVE[next_col];
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic fifo_drop;

    kp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (4)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_data   (push_code),
        .in_drop   (fifo_drop),
        .out_valid (key_valid),
        .out_ready (key_ready),
        .out_data  (key_code)
    );

    // One-cycle overflow pulse for a key the FIFO could not take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow <= 1'b0;
        else     overflow <= fifo_drop;
    end
`else
    // Single-entry output register; a new key is dropped while one is stuck.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (push) begin
                if (key_valid && !key_ready) begin
                    overflow <= 1'b1;
                end else begin
                    key_code  <= push_code;
                    key_valid <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner with a
// behavioural key matrix and an expected-code scoreboard.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_held;
    logic       overflow;

    logic [15:0] pressed;          // index r*4+c
    logic [3:0]  sb [$];
    logic [3:0]  exp_code;
    logic [3:0]  cols_seen;
    int checks, errors;
    int deliveries, ovf_cnt, valid_cycles;
    bit held_seen;

    typedef struct {
        int         r;
        int         c;
        logic [3:0] code;
    } vec_t;
    vec_t vecs [8];

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_held  (key_held),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its row low while its column is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    // Output monitor and scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ($countones(~col_n) != 1) begin
                errors++;
                $display("FAIL col_onecold actual=%b required=one low bit", col_n);
            end
            cols_seen = cols_seen | ~col_n;
            if (key_valid) valid_cycles++;
            if (key_held) held_seen = 1'b1;
            if (overflow) ovf_cnt++;
            if (key_valid && key_ready) begin
                deliveries++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_key actual=%h required=none", key_code);
                end else begin
                    exp_code = sb.pop_front();
                    if (key_code !== exp_code) begin
                        errors++;
                        $display("FAIL key_code actual=%h required=%h", key_code, exp_code);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    task automatic wait_held(input logic lvl, input string name);
        int n = 0;
        while (key_held !== lvl && n < 300) begin
            tick(1);
            n++;
        end
        check(name, {31'd0, key_held}, {31'd0, lvl});
    endtask

    task automatic press_release(input int r, input int c, input string name);
        pressed[r*4+c] = 1'b1;
        wait_held(1'b1, name);
        tick(6);
        pressed = '0;
        wait_held(1'b0, name);
        tick(2);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0, o0, n;
        logic [3:0] ecol;

        vecs[0] = '{r: 0, c: 0, code: 4'h1};
        vecs[1] = '{r: 0, c: 3, code: 4'hA};
        vecs[2] = '{r: 1, c: 1, code: 4'h5};
        vecs[3] = '{r: 2, c: 2, code: 4'h9};
        vecs[4] = '{r: 2, c: 3, code: 4'hC};
        vecs[5] = '{r: 3, c: 1, code: 4'h0};
        vecs[6] = '{r: 3, c: 2, code: 4'hF};
        vecs[7] = '{r: 3, c: 3, code: 4'hD};

        checks = 0; errors = 0; deliveries = 0; ovf_cnt = 0; valid_cycles = 0;
        held_seen = 1'b0; cols_seen = '0;
        rst = 1'b1; key_ready = 1'b1; pressed = '0;
        tick(3);
        check("rst_col_n", col_n, 4'b1110);
        check("rst_key_code", key_code, 4'h0);
        check("rst_key_valid", key_valid, 1'b0);
        check("rst_key_held", key_held, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // Idle scan: each column pattern lasts 4 clocks, wrapping 3 -> 0.
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            ecol = ~(4'b0001 << ((k / 4) % 4));
            check("scan_col_n", col_n, ecol);
            check("scan_key_valid", key_valid, 1'b0);
            tick(1);
        end

        // (r1,c2) held for 20 clocks with key_ready high.
        valid_cycles = 0;
        sb.push_back(4'h6);
        d0 = deliveries;
        pressed[1*4+2] = 1'b1;
        wait_held(1'b1, "k6_held");
        tick(20);
        pressed = '0;
        n = 0;
        while (key_held && n < 40) begin
            tick(1);
            n++;
        end
        check("k6_release_hold", (n >= 8 && n <= 12), 1);
        check("k6_deliveries", deliveries - d0, 1);
        check("k6_valid_cycles", valid_cycles, 1);
        tick(2);

        // Table of single presses across the code map.
        for (int i = 0; i < 8; i++) begin
            d0 = deliveries;
            sb.push_back(vecs[i].code);
            press_release(vecs[i].r, vecs[i].c, "vec_held");
            check("vec_deliveries", deliveries - d0, 1);
            check("vec_sb_empty", sb.size(), 0);
        end

        // Bouncing contact at (r3,c0): 3 on / 2 off, then stable.
        d0 = deliveries;
        sb.push_back(4'hE);
        for (int b = 0; b < 4; b++) begin
            pressed[12] = 1'b1;
            tick(3);
            pressed[12] = 1'b0;
            tick(2);
        end
        press_release(3, 0, "bounce_held");
        tick(20);
        check("bounce_deliveries", deliveries - d0, 1);

        // Ghost: rows 0 and 2 low on the same column.
        d0 = deliveries;
        held_seen = 1'b0;
        cols_seen = '0;
        pressed[0*4+1] = 1'b1;
        pressed[2*4+1] = 1'b1;
        tick(60);
        pressed = '0;
        tick(4);
        check("ghost_deliveries", deliveries - d0, 0);
        check("ghost_held", held_seen, 1'b0);
        check("ghost_scan", cols_seen, 4'hF);

        // Five keys with key_ready low.
        d0 = deliveries;
        o0 = ovf_cnt;
        key_ready = 1'b0;
`ifdef KEYPAD_FIFO_EN
        sb.push_back(4'h1); sb.push_back(4'h2); sb.push_back(4'h3); sb.push_back(4'h4);
`else
        sb.push_back(4'h1);
`endif
        press_release(0, 0, "ovf_held");
        press_release(0, 1, "ovf_held");
        press_release(0, 2, "ovf_held");
        press_release(1, 0, "ovf_held");
        press_release(1, 1, "ovf_held");
        check("ovf_stall_code", key_code, 4'h1);
        check("ovf_stall_valid", key_valid, 1'b1);
`ifdef KEYPAD_FIFO_EN
        check("ovf_pulses", ovf_cnt - o0, 1);
`else
        check("ovf_pulses", ovf_cnt - o0, 4);
`endif
        key_ready = 1'b1;
        tick(10);
`ifdef KEYPAD_FIFO_EN
        check("ovf_deliveries", deliveries - d0, 4);
`else
        check("ovf_deliveries", deliveries - d0, 1);
`endif
        check("ovf_sb_empty", sb.size(), 0);
        check("ovf_drained", key_valid, 1'b0);

        // Reset while confirming a press at (r0,c0).
        rst = 1'b1;
        pressed = '0;
        pressed[0] = 1'b1;
        tick(2);
        rst = 1'b0;
        d0 = deliveries;
        held_seen = 1'b0;
        tick(6);
        check("confirm_col_held", col_n, 4'b1110);
        rst = 1'b1;
        tick(1);
        check("midrst_col_n", col_n, 4'b1110);
        check("midrst_key_valid", key_valid, 1'b0);
        check("midrst_key_held", key_held, 1'b0);
        pressed = '0;
        tick(3);
        rst = 1'b0;
        check("resume_col_n", col_n, 4'b1110);
        tick(40);
        check("midrst_deliveries", deliveries - d0, 0);
        check("midrst_held", held_seen, 1'b0);
        check("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
